iob_counter_seq: RTL and testbench



---
 rtl/iob_counter_seq_if.sv | 31 +++
 rtl/iob_counter_seq.sv | 113 +++++++++++
 tb/tb_iob_counter_seq.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iob_counter_seq_if.sv
// Control/status bundle between a counter sequencer and its environment.
// The slave side is the sequencer; the master side drives requests and the counter value.
interface iob_counter_seq_if #(
    parameter int DATA_W = 32,
    parameter int REP_W  = 16
);
    logic              cke_i;
    logic              start_i;
    logic              stop_i;
    logic [DATA_W-1:0] start_val_i;
    logic [DATA_W-1:0] end_val_i;
    logic [REP_W-1:0]  repeat_i;
    logic [DATA_W-1:0] cnt_i;
    logic              cnt_en_o;
    logic              cnt_ld_o;
    logic [DATA_W-1:0] cnt_ld_val_o;
    logic              busy_o;
    logic              wrap_o;
    logic              done_o;
    logic [REP_W-1:0]  pass_o;

    modport master (
        output cke_i, start_i, stop_i, start_val_i, end_val_i, repeat_i, cnt_i,
        input  cnt_en_o, cnt_ld_o, cnt_ld_val_o, busy_o, wrap_o, done_o, pass_o
    );

    modport slave (
        input  cke_i, start_i, stop_i, start_val_i, end_val_i, repeat_i, cnt_i,
        output cnt_en_o, cnt_ld_o, cnt_ld_val_o, busy_o, wrap_o, done_o, pass_o
    );
endinterface

// File: rtl/iob_counter_seq.sv
// Sequencer driving a loadable up-counter through start..end passes, with
// optional repeat count, abort, and pass/terminal/done reporting.
module iob_counter_seq #(
    parameter int DATA_W = 32,
    parameter int REP_W  = 16
) (
    input logic              clk_i,
    input logic              rst_n_i,
    iob_counter_seq_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] start_val_q, start_val_d;
    logic [DATA_W-1:0] end_val_q, end_val_d;
    logic [REP_W-1:0]  repeat_q, repeat_d;
    logic [REP_W-1:0]  pass_q, pass_d;
    logic              busy_q, busy_d;

    logic cnt_en, cnt_ld, wrap, done;
    logic terminal, last_pass;

    assign terminal  = (bus.cnt_i == end_val_q);
    // repeat of zero means the pass count is never exhausted
    assign last_pass = (repeat_q != '0) && (pass_q == repeat_q - REP_W'(1));

    always_comb begin
        state_d     = state_q;
        start_val_d = start_val_q;
        end_val_d   = end_val_q;
        repeat_d    = repeat_q;
        pass_d      = pass_q;
        cnt_en      = 1'b0;
        cnt_ld      = 1'b0;
        wrap        = 1'b0;
        done        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    start_val_d = bus.start_val_i;
                    end_val_d   = bus.end_val_i;
                    repeat_d    = bus.repeat_i;
                    pass_d      = '0;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                if (bus.stop_i) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_en  = 1'b1;
                    cnt_ld  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.stop_i) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_en = 1'b1;
                    if (terminal) begin
                        wrap   = 1'b1;
                        pass_d = pass_q + REP_W'(1);
                        if (last_pass) begin
                            cnt_en  = 1'b0;
                            state_d = S_DONE;
                        end else begin
                            // reload on the terminal cycle so passes run back to back
                            cnt_ld = 1'b1;
                        end
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_LOAD) || (state_d == S_RUN);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            start_val_q <= '0;
            end_val_q   <= '0;
            repeat_q    <= '0;
            pass_q      <= '0;
            busy_q      <= 1'b0;
        end else if (bus.cke_i) begin
            state_q     <= state_d;
            start_val_q <= start_val_d;
            end_val_q   <= end_val_d;
            repeat_q    <= repeat_d;
            pass_q      <= pass_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.cnt_en_o     = cnt_en;
    assign bus.cnt_ld_o     = cnt_ld;
    assign bus.cnt_ld_val_o = start_val_q;
    assign bus.busy_o       = busy_q;
    assign bus.wrap_o       = wrap;
    assign bus.done_o       = done;
    assign bus.pass_o       = pass_q;
endmodule

// File: tb/tb_iob_counter_seq.sv
// Bench for iob_counter_seq with a behavioural loadable counter closing the loop
// through cnt_i; DATA_W=4 and REP_W=4 so value and pass wrap-around are reachable.
module tb_iob_counter_seq;
    localparam int DW = 4;
    localparam int RW = 4;

    logic clk;
    logic rst_n;
    logic [DW-1:0] cnt_m;
    int n_checks = 0;
    int n_fail   = 0;

    iob_counter_seq_if #(.DATA_W(DW), .REP_W(RW)) bus ();

    iob_counter_seq #(.DATA_W(DW), .REP_W(RW)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // loadable up-counter sitting downstream of the sequencer
    always @(posedge clk) begin
        if (!rst_n)
            cnt_m <= '0;
        else if (bus.cke_i && bus.cnt_en_o)
            cnt_m <= bus.cnt_ld_o ? bus.cnt_ld_val_o : cnt_m + 1'b1;
    end
    assign bus.cnt_i = cnt_m;

    typedef struct {
        int sv;
        int ev;
        int rep;
        int exp_first_wrap;
        int exp_wraps;
        int exp_done;
        int exp_pass;
        int exp_hold;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic launch(input int sv, input int ev, input int rep);
        bus.start_i     = 1'b1;
        bus.start_val_i = DW'(sv);
        bus.end_val_i   = DW'(ev);
        bus.repeat_i    = RW'(rep);
    endtask

    task automatic rand_runs(input int nruns);
        for (int r = 0; r < nruns; r++) begin
            int sv, ev, rep, n, k, limit, e_pass, frozen, last_k;
            bit active;
            sv  = $urandom_range(0, 15);
            ev  = $urandom_range(0, 15);
            rep = $urandom_range(0, 3);
            n   = ((ev - sv) % 16 + 16) % 16 + 1;
            last_k = 2 + rep * n;
            bus.cke_i  = 1'b1;
            bus.stop_i = 1'b0;
            launch(sv, ev, rep);
            #1;
            check("r_idle_busy", bus.busy_o, 0);
            check("r_idle_en", bus.cnt_en_o, 0);
            tick();
            k = 1; limit = 0; active = 1'b1; frozen = 0;
            while (active && limit < 300) begin
                bit e_busy, e_done, e_en, e_ld, e_wrap, stop;
                limit++;
                bus.cke_i       = ($urandom_range(0, 3) != 0);
                stop            = (rep == 0 && limit > 30) ? ($urandom_range(0, 3) == 0)
                                                           : ($urandom_range(0, 40) == 0);
                bus.stop_i      = stop;
                bus.start_i     = $urandom_range(0, 1);
                bus.start_val_i = DW'($urandom_range(0, 15));
                bus.end_val_i   = DW'($urandom_range(0, 15));
                bus.repeat_i    = RW'($urandom_range(0, 15));
                #1;
                e_wrap = 0; e_done = 0;
                if (k == 1) begin
                    e_pass = 0; e_busy = 1; e_en = !stop; e_ld = !stop;
                end else if (rep != 0 && k == last_k) begin
                    e_pass = rep; e_busy = 0; e_done = 1; e_en = 0; e_ld = 0;
                end else begin
                    int j, p, pos;
                    bit term, lastp;
                    j = k - 2; p = j / n; pos = j % n;
                    term  = (pos == n - 1);
                    lastp = (rep != 0) && (p == rep - 1);
                    e_pass = p % 16; e_busy = 1;
                    e_wrap = term && !stop;
                    e_en   = !stop && !(term && lastp);
                    e_ld   = !stop && term && !lastp;
                    check("r_cnt", bus.cnt_i, (sv + pos) % 16);
                end
                check("r_busy", bus.busy_o, e_busy);
                check("r_done", bus.done_o, e_done);
                check("r_en", bus.cnt_en_o, e_en);
                check("r_ld", bus.cnt_ld_o, e_ld);
                check("r_wrap", bus.wrap_o, e_wrap);
                check("r_pass", bus.pass_o, e_pass);
                check("r_ldval", bus.cnt_ld_val_o, sv);
                if (bus.cke_i) begin
                    if (e_done || stop) begin
                        active = 1'b0;
                        frozen = e_pass;
                    end else begin
                        k++;
                    end
                end
                tick();
            end
            bus.cke_i = 1'b1; bus.stop_i = 1'b0; bus.start_i = 1'b0;
            #1;
            check("r_end_busy", bus.busy_o, 0);
            check("r_end_done", bus.done_o, 0);
            check("r_end_pass", bus.pass_o, frozen);
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{5, 8, 1, 5, 1, 6, 1, 8};
        tbl[1] = '{0, 2, 3, 4, 3, 11, 3, 2};
        tbl[2] = '{14, 1, 1, 5, 1, 6, 1, 1};
        tbl[3] = '{3, 3, 4, 2, 4, 6, 4, 3};
        tbl[4] = '{9, 8, 2, 17, 2, 34, 2, 8};

        rst_n = 1'b0;
        bus.cke_i = 1'b1; bus.stop_i = 1'b0; bus.start_i = 1'b0;
        bus.start_val_i = '0; bus.end_val_i = '0; bus.repeat_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_busy", bus.busy_o, 0);
        check("rst_pass", bus.pass_o, 0);
        check("rst_ldval", bus.cnt_ld_val_o, 0);
        check("rst_en", bus.cnt_en_o, 0);
        check("rst_ld", bus.cnt_ld_o, 0);
        check("rst_wrap", bus.wrap_o, 0);
        check("rst_done", bus.done_o, 0);
        rst_n = 1'b1;
        tick();

        // table of complete runs
        for (int i = 0; i < 5; i++) begin
            int done_c, first_w, wraps;
            done_c = -1; first_w = -1; wraps = 0;
            launch(tbl[i].sv, tbl[i].ev, tbl[i].rep);
            for (int c = 0; c < 60; c++) begin
                #1;
                if (c == 1) check("t_load_ld", bus.cnt_ld_o, 1);
                if (c == 2) check("t_first_cnt", bus.cnt_i, tbl[i].sv);
                if (bus.wrap_o) begin
                    wraps++;
                    if (first_w < 0) first_w = c;
                end
                if (bus.done_o) begin
                    done_c = c;
                    break;
                end
                tick();
                bus.start_i = 1'b0;
            end
            check("t_done_cycle", done_c, tbl[i].exp_done);
            check("t_first_wrap", first_w, tbl[i].exp_first_wrap);
            check("t_wraps", wraps, tbl[i].exp_wraps);
            check("t_done_busy", bus.busy_o, 0);
            check("t_pass", bus.pass_o, tbl[i].exp_pass);
            tick();
            #1;
            check("t_hold_cnt", bus.cnt_i, tbl[i].exp_hold);
            check("t_idle_pass", bus.pass_o, tbl[i].exp_pass);
            check("t_idle_done", bus.done_o, 0);
        end

        // infinite run, ignored start mid-run, then stop on a terminal cycle
        launch(0, 1, 0);
        tick();
        for (int c = 1; c < 13; c++) begin
            bus.start_i     = (c == 5);
            bus.start_val_i = (c == 5) ? DW'(9) : DW'(0);
            tick();
        end
        #1;
        check("inf_pass", bus.pass_o, 5);
        check("inf_cnt", bus.cnt_i, 1);
        check("inf_ldval", bus.cnt_ld_val_o, 0);
        bus.stop_i = 1'b1;
        #1;
        check("stop_wrap", bus.wrap_o, 0);
        check("stop_en", bus.cnt_en_o, 0);
        check("stop_ld", bus.cnt_ld_o, 0);
        tick();
        bus.stop_i = 1'b0;
        #1;
        check("stop_busy", bus.busy_o, 0);
        check("stop_done", bus.done_o, 0);
        check("stop_pass", bus.pass_o, 5);
        tick();
        #1;
        check("stop_done2", bus.done_o, 0);
        check("stop_pass2", bus.pass_o, 5);

        // clock enable dropped for three cycles mid-pass
        begin
            int done_c;
            done_c = -1;
            launch(0, 7, 1);
            for (int c = 0; c < 40; c++) begin
                bus.cke_i = !(c >= 4 && c < 7);
                #1;
                if (c >= 4 && c <= 7) begin
                    check("cke_cnt", bus.cnt_i, 2);
                    check("cke_busy", bus.busy_o, 1);
                    check("cke_pass", bus.pass_o, 0);
                end
                if (bus.done_o) begin
                    done_c = c;
                    break;
                end
                tick();
                bus.start_i = 1'b0;
            end
            bus.cke_i = 1'b1;
            check("cke_done_cycle", done_c, 13);
            check("cke_final_pass", bus.pass_o, 1);
            tick();
        end

        // reset in the middle of a run
        launch(2, 9, 2);
        tick();
        bus.start_i = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        #1;
        check("mrst_busy", bus.busy_o, 0);
        check("mrst_pass", bus.pass_o, 0);
        check("mrst_ldval", bus.cnt_ld_val_o, 0);
        check("mrst_en", bus.cnt_en_o, 0);
        check("mrst_done", bus.done_o, 0);
        rst_n = 1'b1;
        tick();
        #1;
        check("mrst_idle_done", bus.done_o, 0);

        // abort while loading
        launch(4, 6, 1);
        tick();
        bus.start_i = 1'b0;
        bus.stop_i  = 1'b1;
        #1;
        check("lstop_en", bus.cnt_en_o, 0);
        check("lstop_ld", bus.cnt_ld_o, 0);
        check("lstop_busy", bus.busy_o, 1);
        tick();
        bus.stop_i = 1'b0;
        #1;
        check("lstop_idle", bus.busy_o, 0);
        check("lstop_done", bus.done_o, 0);
        tick();

        rand_runs(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
